// File: rtl/div_if.sv
// Execute-to-divider handshake: request operands/op in, quotient or remainder out.
interface div_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [1:0]       op;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] result;

  modport master (
    output req_valid, A, B, op, resp_ready,
    input  req_ready, resp_valid, result
  );

  modport slave (
    input  req_valid, A, B, op, resp_ready,
    output req_ready, resp_valid, result
  );
endinterface

// File: rtl/div_unit.sv
// RV32M DIV/DIVU/REM/REMU radix-2 restoring divider, one quotient bit per cycle.
// Optional macro DIV_EARLY_OUT_EN: answer |A| < |B| in one cycle without iterating.
module div_unit #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 6
) (
  input logic   clk,
  input logic   rst,
  input logic   flush,
  div_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [WIDTH-1:0]     rem;
  logic [WIDTH-1:0]     quo;
  logic [WIDTH-1:0]     dvsr;
  logic                 is_signed;
  logic                 is_rem;
  logic                 q_neg;
  logic                 r_neg;
  logic                 resp_valid;
  logic [WIDTH-1:0]     result;

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = resp_valid;
  assign bus.result     = result;

  // Accept-side decode of the incoming request.
  logic             op_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic             b_zero;
  logic             ovf;
  logic             early;
  logic             fast;
  logic [WIDTH-1:0] fast_res;

  always_comb begin
    op_signed = ~bus.op[0];
    a_neg     = op_signed & bus.A[WIDTH-1];
    b_neg     = op_signed & bus.B[WIDTH-1];
    abs_a     = a_neg ? -bus.A : bus.A;
    abs_b     = b_neg ? -bus.B : bus.B;
    b_zero    = (bus.B == '0);
    ovf       = op_signed & (bus.A == {1'b1, {(WIDTH-1){1'b0}}}) & (bus.B == '1);
`ifdef DIV_EARLY_OUT_EN
    early     = ~b_zero & (abs_a < abs_b);
`else
    early     = 1'b0;
`endif
    fast      = b_zero | ovf | early;
    // Divide-by-zero and early-out both return A as remainder; overflow returns A as quotient.
    if (b_zero)
      fast_res = bus.op[1] ? bus.A : '1;
    else if (ovf)
      fast_res = bus.op[1] ? '0 : bus.A;
    else
      fast_res = bus.op[1] ? bus.A : '0;
  end

  // One restoring step; the WIDTH+1-bit trial sign tells whether the divisor fits.
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic             last;

  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    trial   = shifted - {1'b0, dvsr};
    if (!trial[WIDTH]) begin
      rem_nx = trial[WIDTH-1:0];
      quo_nx = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_nx = shifted[WIDTH-1:0];
      quo_nx = {quo[WIDTH-2:0], 1'b0};
    end
    quo_fix = (is_signed & q_neg) ? -quo_nx : quo_nx;
    rem_fix = (is_signed & r_neg) ? -rem_nx : rem_nx;
    last    = (cnt == CNT_WIDTH'(WIDTH - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      rem        <= '0;
      quo        <= '0;
      dvsr       <= '0;
      is_signed  <= 1'b0;
      is_rem     <= 1'b0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
      resp_valid <= 1'b0;
      result     <= '0;
    end else if (flush) begin
      state      <= IDLE;
      cnt        <= '0;
      resp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            is_signed <= op_signed;
            is_rem    <= bus.op[1];
            q_neg     <= a_neg ^ b_neg;
            r_neg     <= a_neg;
            cnt       <= '0;
            if (fast) begin
              result     <= fast_res;
              resp_valid <= 1'b1;
              state      <= DONE;
            end else begin
              rem   <= '0;
              quo   <= abs_a;
              dvsr  <= abs_b;
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt + 1'b1;
          if (last) begin
            result     <= is_rem ? rem_fix : quo_fix;
            resp_valid <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          if (bus.resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle iterative divider for the execute stage; the responder side of the execute-to-functional-unit handshake.
- Execute issues operands and a divide op.
- Block returns quotient or remainder via valid/ready.
- Implements RV32M DIV/DIVU/REM/REMU with RISC-V-defined divide-by-zero and overflow results. Radix-2 restoring algorithm, one bit per cycle.

Parameters:
- WIDTH, 32, operand/result width (matches OPERANDS_WIDTH).
- CNT_WIDTH, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous kill from pipeline; aborts any operation.
- req_valid  input  1  operands and op valid.
- req_ready  output  1  unit can accept a request (high only in IDLE).
- A  input  WIDTH  dividend.
- B  input  WIDTH  divisor.
- op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- resp_valid  output  1  result valid.
- resp_ready  input  1  consumer accepts result.
- result  output  WIDTH  quotient (DIV/DIVU) or remainder (REM/REMU).

Behaviour:
- Reset (async, any state): state=IDLE, resp_valid=0, result=0, counter=0, internal regs=0. req_ready=1 while in IDLE, including during reset.
- States: IDLE, CALC, DONE.
- IDLE:
  - Accept on the edge where req_valid&req_ready&!flush. Latch op and signedness.
  - Signed ops: latch |A|, |B|; record q_neg = A[msb]^B[msb] and r_neg = A[msb]. Unsigned ops: latch raw values, no sign fix.
- Special cases, detected at accept, go directly to DONE so resp_valid rises the cycle after acceptance:
  - B==0: quotient = all ones, remainder = A (unmodified, any op).
  - Signed overflow (DIV/REM, A=100..0, B=all ones): quotient = A, remainder = 0.
- Normal case, IDLE->CALC with counter=0.
- CALC, per cycle:
  - Shift {rem,quo} left 1; trial = rem - divisor (WIDTH+1 bits).
  - If trial non-negative, rem=trial and quo LSB=1.
  - Counter increments; after WIDTH CALC edges go to DONE.
  - On the final edge, apply sign fix (negate quo if q_neg, rem if r_neg, signed ops only), select quo/rem per op, register into result, set resp_valid=1.
  - Total: resp_valid first high WIDTH cycles after the accept edge.
- DONE:
  - result and resp_valid held stable until resp_ready.
  - On resp_valid&resp_ready: resp_valid=0, go to IDLE. req_ready rises the next cycle, giving one bubble between back-to-back ops.
  - result keeps its last value after handshake.
- flush:
  - In any state, next edge goes to IDLE with resp_valid=0 and no response produced.
  - flush with req_valid in IDLE: no accept.
  - flush with resp_ready in DONE: response dropped (no handshake counted).
- A and B are sampled only at accept; later changes are ignored.
- Reset mid-CALC or mid-DONE: immediate IDLE, no response.

Optional Feature:
- Macro DIV_EARLY_OUT_EN.
- When defined: at accept, if unsigned magnitude |A| < |B| (B!=0), skip CALC. Go to DONE next edge with quotient=0 and remainder = original A (signed ops keep A's sign naturally). Latency is 1 cycle.
- When undefined: these cases take the full WIDTH-cycle CALC path; results are bit-identical.
- Special cases (B==0, overflow) are 1-cycle in both builds.

Test Plan:
- DIVU A=100, B=7, resp_ready=1 -> result=14, resp_valid exactly 32 cycles after accept. Same operands with REMU -> 2.
- DIV A=-7 (0xFFFFFFF9), B=2 -> 0xFFFFFFFD (-3); REM -> 0xFFFFFFFF (-1). DIV A=7, B=-2 -> 0xFFFFFFFD.
- DIVU A=5, B=0 -> 0xFFFFFFFF; REM A=5, B=0 -> 5; DIV A=0x80000000, B=0xFFFFFFFF -> 0x80000000; REM same operands -> 0. All with resp_valid 1 cycle after accept.
- Backpressure: DIVU 100/7 with resp_ready=0 for 5 cycles -> result=14 and resp_valid held stable; req_ready=0 until 1 cycle after handshake.
- flush pulsed at CALC cycle 10 -> no resp_valid ever; req_ready=1 next cycle. A new DIVU 9/3 then returns 3.
- rst asserted asynchronously mid-CALC -> resp_valid=0, result=0, req_ready=1 without a clock edge. With DIV_EARLY_OUT_EN, DIVU 3/10 -> result 0 after 1 cycle; REMU 3/10 -> 3.
